uart_hex_display_ctrl: RTL and testbench
========================================

Name: uart_hex_display_ctrl

Overview:
- Command controller between the UART receiver (byte + data-valid strobe) and the two Binary_To_7Segment digit converters.
- Parses the received byte stream as ASCII hex pairs and single-character commands.
- Holds the committed display byte; the upper nibble drives digit 1 and the lower nibble drives digit 2.
- Sequences blanking and blinking of both digits, and aborts stale partial pairs via an inter-byte timeout.

Parameters:
TIMEOUT_CLKS, 2500000, max clocks allowed between the first and second hex char of a pair (100 ms at 25 MHz)
BLINK_CLKS, 6250000, blink half-period in clocks (250 ms at 25 MHz)

Ports:
i_Clk  input  1  system clock, 25 MHz
i_Reset  input  1  reset, asynchronous, active-high
i_RX_DV  input  1  one-cycle strobe: i_RX_Byte valid
i_RX_Byte  input  8  received byte
o_Display_Byte  output  8  committed value; [7:4] feeds digit 1, [3:0] feeds digit 2
o_Digit1_En  output  1  1 = digit 1 lit; top level gates segments with it
o_Digit2_En  output  1  1 = digit 2 lit
o_Update_Pulse  output  1  one-cycle pulse, concurrent with each o_Display_Byte change
o_Error  output  1  one-cycle pulse on protocol error or timeout

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high.
- Reset values:
  - o_Display_Byte = 8'h00, o_Digit1_En = 1, o_Digit2_En = 1, o_Update_Pulse = 0, o_Error = 0.
  - state = IDLE, blank = 0, blink_en = 0, blink_phase = 1, hi_nibble = 0, timeout counter = 0, blink counter = 0.
- Character classes (decoded only when i_RX_DV = 1):
  - HEX: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66); value 0-15.
  - CMD_BLINK '*' (0x2A): toggle blink_en.
  - CMD_BLANK '-' (0x2D): blank = 1.
  - CMD_SHOW '=' (0x3D): blank = 0.
  - IGNORE: CR (0x0D), LF (0x0A); no effect in any state.
  - Anything else is OTHER.
- FSM, two states:
  - IDLE + HEX: hi_nibble <= value; go to HAVE_HI; clear timeout counter.
  - IDLE + CMD: execute the command; stay in IDLE.
  - IDLE + OTHER: o_Error pulse; stay in IDLE.
  - HAVE_HI + HEX: o_Display_Byte <= {hi_nibble, value}; o_Update_Pulse = 1 in the same cycle the new value appears (registered, 1 cycle after the DV cycle); go to IDLE.
  - HAVE_HI + CMD: execute the command; discard hi_nibble; o_Error pulse; go to IDLE.
  - HAVE_HI + OTHER: discard hi_nibble; o_Error pulse; go to IDLE.
  - HAVE_HI + IGNORE: stay in HAVE_HI; timeout counter keeps running (not restarted).
  - HAVE_HI, no HEX/CMD/OTHER byte: timeout counter increments each clock. When it reaches TIMEOUT_CLKS-1: o_Error pulse; go to IDLE; o_Display_Byte unchanged.
  - Simultaneous i_RX_DV and terminal timeout count: the byte wins; it is processed normally and no timeout error is raised.
- Blink:
  - blink_en = 0: counter held at 0 and blink_phase held at 1.
  - blink_en = 1: counter counts 0..BLINK_CLKS-1 then wraps; blink_phase toggles on each wrap.
  - Enabling blink starts from counter = 0, phase = 1, so the display is lit for the first half-period.
  - Disabling blink forces phase = 1 immediately (next cycle).
- Enables: o_DigitN_En = ~blank & (~blink_en | blink_phase). Registered, 1-cycle latency from the command DV. Both digits are always equal.
- o_Display_Byte is unaffected by blank, blink and errors; only a completed pair changes it.
- Pulse timing: o_Update_Pulse and o_Error never stay high more than 1 cycle. An error and an update cannot occur on the same byte.
- Reset asserted mid-pair or mid-blink: all state returns to reset values immediately; a partial pair is lost silently (no o_Error).

Test Plan:
Bench uses TIMEOUT_CLKS=20, BLINK_CLKS=8.
1. Reset release, then DV bytes '3','C' (0x33,0x43) -> o_Display_Byte=8'h3C one cycle after the second DV, o_Update_Pulse high exactly that cycle, enables stay 1.
2. 'a' then 'Z' (0x5A) -> o_Error 1-cycle pulse, o_Display_Byte keeps prior value; next '0','7' -> 8'h07 with update pulse.
3. '5', then 25 idle clocks -> o_Error pulse 20 clocks after the '5' DV, state IDLE; next '9','1' -> 8'h91 (not 8'h59).
4. '*' -> enables toggle every 8 clocks starting high; '-' -> both enables 0 steady; '=' -> blinking resumes; '*' -> enables 1 steady next cycle.
5. '4', CR (0x0D), 'E' -> 8'h4E with no error; '4' then '*' -> o_Error pulse, blink_en set, byte unchanged.
6. '6' then i_Reset asserted mid-pair -> all outputs at reset values asynchronously, no o_Error; after release 'F','F' -> 8'hFF.

Source files
------------

// File: rtl/uart_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_hex_display_ctrl
// Function : Parses UART bytes as ASCII hex pairs and one-character commands.
//            Holds the committed display byte and drives blank/blink enables
//            for the two seven-segment digits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_hex_display_ctrl #(
    parameter int TIMEOUT_CLKS = 2500000,
    parameter int BLINK_CLKS   = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic [7:0] o_Display_Byte,
    output logic       o_Digit1_En,
    output logic       o_Digit2_En,
    output logic       o_Update_Pulse,
    output logic       o_Error
);

    localparam int c_TO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int c_BL_W = (BLINK_CLKS > 2) ? $clog2(BLINK_CLKS) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [c_BL_W-1:0] c_BL_LAST = c_BL_W'(BLINK_CLKS - 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_HAVE_HI = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [3:0]        r_hi_nibble;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_BL_W-1:0] r_bl_cnt;
    logic [c_BL_W-1:0] w_bl_cnt_next;
    logic              r_blank;
    logic              r_blink_en;
    logic              r_blink_phase;
    logic              r_digit_en;
    logic              w_blank_next;
    logic              w_blink_en_next;
    logic              w_phase_next;
    logic              w_en_next;

    // Decoded byte classes (all zero when no byte is valid)
    logic       w_is_hex;
    logic       w_is_blink;
    logic       w_is_blank;
    logic       w_is_show;
    logic       w_is_cmd;
    logic       w_is_other;
    logic [3:0] w_hex_val;
    logic       w_to_done;

    // FSM actions
    logic       w_load_hi;
    logic       w_commit;
    logic       w_err_next;

    // Classify the incoming byte; CR/LF fall through with every flag low
    always_comb begin
        w_is_hex   = 1'b0;
        w_is_blink = 1'b0;
        w_is_blank = 1'b0;
        w_is_show  = 1'b0;
        w_is_other = 1'b0;
        w_hex_val  = 4'd0;
        if (i_RX_DV) begin
            if (i_RX_Byte >= 8'h30 && i_RX_Byte <= 8'h39) begin
                w_is_hex  = 1'b1;
                w_hex_val = i_RX_Byte[3:0];
            end else if ((i_RX_Byte >= 8'h41 && i_RX_Byte <= 8'h46) ||
                         (i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h66)) begin
                w_is_hex  = 1'b1;
                w_hex_val = i_RX_Byte[3:0] + 4'd9;
            end else if (i_RX_Byte == 8'h2A) begin
                w_is_blink = 1'b1;
            end else if (i_RX_Byte == 8'h2D) begin
                w_is_blank = 1'b1;
            end else if (i_RX_Byte == 8'h3D) begin
                w_is_show = 1'b1;
            end else if (i_RX_Byte != 8'h0D && i_RX_Byte != 8'h0A) begin
                w_is_other = 1'b1;
            end
        end
    end

    assign w_is_cmd  = w_is_blink | w_is_blank | w_is_show;
    assign w_to_done = (r_to_cnt == c_TO_LAST);

    // State register
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a real byte takes priority over the timeout
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_is_hex) w_state_next = S_HAVE_HI;
            end
            S_HAVE_HI: begin
                if (w_is_hex || w_is_cmd || w_is_other || w_to_done)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM action decode: load high nibble, commit pair, or flag an error
    always_comb begin
        w_load_hi  = 1'b0;
        w_commit   = 1'b0;
        w_err_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load_hi  = w_is_hex;
                w_err_next = w_is_other;
            end
            S_HAVE_HI: begin
                w_commit   = w_is_hex;
                w_err_next = w_is_cmd | w_is_other |
                             (w_to_done & ~(w_is_hex | w_is_cmd | w_is_other));
            end
            default: ;
        endcase
    end

    // Blink/blank next values; commands execute in either state
    always_comb begin
        w_blink_en_next = r_blink_en ^ w_is_blink;
        w_blank_next    = w_is_blank ? 1'b1 : (w_is_show ? 1'b0 : r_blank);
        w_bl_cnt_next   = '0;
        w_phase_next    = 1'b1;
        if (w_blink_en_next && r_blink_en) begin
            if (r_bl_cnt == c_BL_LAST) begin
                w_phase_next = ~r_blink_phase;
            end else begin
                w_bl_cnt_next = r_bl_cnt + c_BL_W'(1);
                w_phase_next  = r_blink_phase;
            end
        end
        w_en_next = ~w_blank_next & (~w_blink_en_next | w_phase_next);
    end

    // Datapath registers: pair assembly, timeout, blink and outputs
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_hi_nibble    <= 4'd0;
            r_to_cnt       <= '0;
            r_bl_cnt       <= '0;
            r_blank        <= 1'b0;
            r_blink_en     <= 1'b0;
            r_blink_phase  <= 1'b1;
            r_digit_en     <= 1'b1;
            o_Display_Byte <= 8'h00;
            o_Update_Pulse <= 1'b0;
            o_Error        <= 1'b0;
        end else begin
            if (w_load_hi) r_hi_nibble <= w_hex_val;
            if (w_state_next != S_HAVE_HI || w_load_hi) r_to_cnt <= '0;
            else                                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
            r_bl_cnt       <= w_bl_cnt_next;
            r_blank        <= w_blank_next;
            r_blink_en     <= w_blink_en_next;
            r_blink_phase  <= w_phase_next;
            r_digit_en     <= w_en_next;
            if (w_commit) o_Display_Byte <= {r_hi_nibble, w_hex_val};
            o_Update_Pulse <= w_commit;
            o_Error        <= w_err_next;
        end
    end

    assign o_Digit1_En = r_digit_en;
    assign o_Digit2_En = r_digit_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_hex_display_ctrl
// Function : Self-checking bench: vector table, directed corner sequences and
//            randomized bytes against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_hex_display_ctrl;

    localparam int TIMEOUT = 20;
    localparam int BLINK   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv  = 1'b0;
    logic [7:0] rx  = 8'h00;
    logic [7:0] disp;
    logic       en1, en2, upd, err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: events are remembered by the cycle they happened
    int       m_cyc;
    logic [7:0] m_disp;
    bit       m_pending;
    logic [3:0] m_hi;
    int       m_pend_cyc;
    bit       m_blank, m_blink;
    int       m_blink_cyc;
    bit       m_upd, m_err, m_en;

    typedef struct {
        logic       dv;
        logic [7:0] b;
        logic [7:0] disp;
        logic       upd;
        logic       err;
        logic       en;
    } vec_t;

    vec_t vecs[18];

    uart_hex_display_ctrl #(.TIMEOUT_CLKS(TIMEOUT), .BLINK_CLKS(BLINK)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_RX_DV(dv), .i_RX_Byte(rx),
        .o_Display_Byte(disp), .o_Digit1_En(en1), .o_Digit2_En(en2),
        .o_Update_Pulse(upd), .o_Error(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_disp = 8'h00; m_pending = 0; m_hi = 4'd0; m_pend_cyc = 0;
        m_blank = 0; m_blink = 0; m_blink_cyc = 0;
        m_upd = 0; m_err = 0; m_en = 1;
    endtask

    // Reference model: advance one clock edge with the given inputs
    task automatic model_edge(input logic d, input logic [7:0] b);
        bit is_hex, is_cmd, is_ign, eff;
        logic [3:0] v;
        m_cyc++;
        m_upd = 0; m_err = 0;
        is_hex = d && ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
                       (b >= 8'h61 && b <= 8'h66));
        is_cmd = d && (b == 8'h2A || b == 8'h2D || b == 8'h3D);
        is_ign = d && (b == 8'h0D || b == 8'h0A);
        eff    = d && !is_ign;
        if (b <= 8'h39)      v = 4'(b - 8'h30);
        else if (b <= 8'h46) v = 4'(b - 8'h37);
        else                 v = 4'(b - 8'h57);
        if (m_pending && !eff && (m_cyc - m_pend_cyc == TIMEOUT)) begin
            m_err = 1; m_pending = 0;
        end
        if (eff) begin
            if (is_hex) begin
                if (m_pending) begin
                    m_disp = {m_hi, v}; m_upd = 1; m_pending = 0;
                end else begin
                    m_pending = 1; m_hi = v; m_pend_cyc = m_cyc;
                end
            end else begin
                if (m_pending || !is_cmd) m_err = 1;
                m_pending = 0;
                if (b == 8'h2A) begin
                    m_blink = !m_blink;
                    if (m_blink) m_blink_cyc = m_cyc;
                end
                if (b == 8'h2D) m_blank = 1;
                if (b == 8'h3D) m_blank = 0;
            end
        end
        m_en = !m_blank && (!m_blink || (((m_cyc - m_blink_cyc) / BLINK) % 2 == 0));
    endtask

    // Drive one clock worth of input, update the model, sample after the edge
    task automatic clk_step(input logic d, input logic [7:0] b);
        dv = d; rx = b;
        @(posedge clk);
        model_edge(d, b);
        #1;
        dv = 1'b0;
    endtask

    task automatic check_model();
        check("model_disp", disp, m_disp);
        check("model_upd",  {7'd0, upd}, {7'd0, m_upd});
        check("model_err",  {7'd0, err}, {7'd0, m_err});
        check("model_en",   {6'd0, en2, en1}, {6'd0, m_en, m_en});
    endtask

    task automatic send(input logic [7:0] b);
        clk_step(1'b1, b);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clk_step(1'b0, 8'h00);
            check_model();
        end
    endtask

    logic [7:0] pool[32];

    initial begin
        m_cyc = 0;
        model_reset();

        // Hand-derived vectors starting from reset
        vecs[0]  = '{1'b1, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1}; // '3'
        vecs[1]  = '{1'b1, 8'h43, 8'h3C, 1'b1, 1'b0, 1'b1}; // 'C'
        vecs[2]  = '{1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'h61, 8'h3C, 1'b0, 1'b0, 1'b1}; // 'a'
        vecs[4]  = '{1'b1, 8'h5A, 8'h3C, 1'b0, 1'b1, 1'b1}; // 'Z'
        vecs[5]  = '{1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'h30, 8'h3C, 1'b0, 1'b0, 1'b1}; // '0'
        vecs[7]  = '{1'b1, 8'h37, 8'h07, 1'b1, 1'b0, 1'b1}; // '7'
        vecs[8]  = '{1'b1, 8'h34, 8'h07, 1'b0, 1'b0, 1'b1}; // '4'
        vecs[9]  = '{1'b1, 8'h0D, 8'h07, 1'b0, 1'b0, 1'b1}; // CR
        vecs[10] = '{1'b1, 8'h45, 8'h4E, 1'b1, 1'b0, 1'b1}; // 'E'
        vecs[11] = '{1'b1, 8'h2D, 8'h4E, 1'b0, 1'b0, 1'b0}; // '-'
        vecs[12] = '{1'b1, 8'h3D, 8'h4E, 1'b0, 1'b0, 1'b1}; // '='
        vecs[13] = '{1'b1, 8'h78, 8'h4E, 1'b0, 1'b1, 1'b1}; // 'x'
        vecs[14] = '{1'b0, 8'h00, 8'h4E, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 8'h34, 8'h4E, 1'b0, 1'b0, 1'b1}; // '4'
        vecs[16] = '{1'b1, 8'h2A, 8'h4E, 1'b0, 1'b1, 1'b1}; // '*' mid-pair
        vecs[17] = '{1'b1, 8'h2A, 8'h4E, 1'b0, 1'b0, 1'b1}; // '*' off

        // Reset, released away from the clock edge
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_disp", disp, 8'h00);
        check("reset_flags", {4'd0, en1, en2, upd, err}, 8'b0000_1100);
        @(posedge clk);
        #1;

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            clk_step(vecs[i].dv, vecs[i].b);
            check($sformatf("vec%0d_disp", i), disp, vecs[i].disp);
            check($sformatf("vec%0d_upd", i), {7'd0, upd}, {7'd0, vecs[i].upd});
            check($sformatf("vec%0d_err", i), {7'd0, err}, {7'd0, vecs[i].err});
            check($sformatf("vec%0d_en", i), {6'd0, en1, en2}, {6'd0, vecs[i].en, vecs[i].en});
            check_model();
        end

        // Timeout: error exactly TIMEOUT clocks after the first nibble
        send(8'h35);
        for (int k = 1; k <= 25; k++) begin
            clk_step(1'b0, 8'h00);
            check("timeout_err", {7'd0, err}, {7'd0, (k == TIMEOUT)});
            check_model();
        end
        send(8'h39);
        send(8'h31);
        check("after_timeout_disp", disp, 8'h91);

        // Blink pattern: lit for BLINK clocks, dark for BLINK clocks
        send(8'h2A);
        check("blink_start_en", {7'd0, en1}, 8'd1);
        for (int k = 1; k < 4 * BLINK; k++) begin
            clk_step(1'b0, 8'h00);
            check("blink_en", {6'd0, en1, en2}, ((k / BLINK) % 2 == 0) ? 8'd3 : 8'd0);
            check_model();
        end
        send(8'h2D);
        idle(2 * BLINK);
        check("blank_steady", {6'd0, en1, en2}, 8'd0);
        send(8'h3D);
        idle(2 * BLINK + 3);
        send(8'h2A);
        check("blink_off_en", {6'd0, en1, en2}, 8'd3);
        idle(2 * BLINK);

        // Asynchronous reset mid-pair with digits blanked
        send(8'h2D);
        send(8'h36);
        #2 rst = 1'b1;
        #1;
        check("async_rst_disp", disp, 8'h00);
        check("async_rst_flags", {4'd0, en1, en2, upd, err}, 8'b0000_1100);
        model_reset();
        #1 rst = 1'b0;
        idle(TIMEOUT + 2);
        send(8'h46);
        send(8'h46);
        check("post_rst_disp", disp, 8'hFF);

        // Randomized traffic against the model
        pool = '{8'h30, 8'h31, 8'h32, 8'h35, 8'h38, 8'h39, 8'h41, 8'h42,
                 8'h44, 8'h46, 8'h61, 8'h63, 8'h66, 8'h37, 8'h34, 8'h45,
                 8'h2A, 8'h2D, 8'h3D, 8'h0D, 8'h0A, 8'h5A, 8'h20, 8'h47,
                 8'h67, 8'h2F, 8'h3A, 8'h40, 8'h60, 8'h33, 8'h62, 8'h43};
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0)
                idle($urandom_range(15, 24));
            clk_step($urandom_range(0, 2) != 0, pool[$urandom_range(0, 31)]);
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
